// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Serial frame format, command encoding, parity helper and the
//               target sequencer state type shared by the serial target path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int unsigned SERIAL_ADDR_W = 14;
    localparam int unsigned SERIAL_DATA_W = 8;
    localparam int unsigned CMD_W         = 2;

    // Two-bit command field leaves 2'b00 and 2'b11 as unsupported codes
    typedef enum logic [CMD_W-1:0] {
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } cmd_e;

    typedef struct packed {
        logic                     start;
        logic [CMD_W-1:0]         cmd;
        logic [SERIAL_ADDR_W-1:0] addr;
        logic [SERIAL_DATA_W-1:0] data;
        logic                     parity;
        logic                     stop;
    } serial_frame_t;

    localparam int unsigned FRAME_WIDTH = $bits(serial_frame_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } tgt_state_e;

    // Even parity over the payload fields: the XOR of cmd, addr and data
    function automatic logic calc_parity(
        input logic [CMD_W-1:0]         cmd,
        input logic [SERIAL_ADDR_W-1:0] addr,
        input logic [SERIAL_DATA_W-1:0] data
    );
        return ^{cmd, addr, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    // Count one per inc_i pulse, holding once the maximum is reached
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/serial_target_ctrl.sv
// ============================================================================
// Module      : serial_target_ctrl
// Description : Target-side sequencer behind the serial deserializer. Checks
//               each received frame, runs it as one local bus read or write
//               and offers a response frame to the serializer. Bad frames,
//               overruns and bus timeouts are counted instead of executed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_target_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     frame_valid_i,
    input  serial_frame_t            frame_i,
    input  logic                     parity_err_i,
    output logic                     req_o,
    output logic                     we_o,
    output logic [SERIAL_ADDR_W-1:0] addr_o,
    output logic [SERIAL_DATA_W-1:0] wdata_o,
    input  logic                     gnt_i,
    input  logic                     rvalid_i,
    input  logic [SERIAL_DATA_W-1:0] rdata_i,
    output logic                     rsp_valid_o,
    output serial_frame_t            rsp_frame_o,
    input  logic                     rsp_ready_i,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         frame_err_o,
    output logic [CNT_W-1:0]         overrun_o,
    output logic [CNT_W-1:0]         timeout_o
);

    // Timer counts TIMEOUT-1 down to 0, giving TIMEOUT cycles per wait phase
    localparam int unsigned     c_TMR_W    = $clog2(TIMEOUT + 1);
    localparam [c_TMR_W-1:0]    c_TMR_LOAD = c_TMR_W'(TIMEOUT - 1);

    tgt_state_e                 r_state;
    logic [c_TMR_W-1:0]         r_timer;
    logic [CMD_W-1:0]           r_cmd;
    logic [SERIAL_ADDR_W-1:0]   r_addr;
    logic [SERIAL_DATA_W-1:0]   r_wdata;
    logic                       r_req;
    logic                       r_we;
    logic                       r_rsp_valid;
    serial_frame_t              r_rsp_frame;

    logic                       w_frame_ok;
    logic                       w_idle;
    logic                       w_accept;
    logic                       w_inc_ferr;
    logic                       w_inc_ovr;
    logic                       w_inc_tmo;
    logic                       w_tmr_zero;
    logic                       w_unused_parity;

    // The incoming parity bit is already judged by the deserializer
    assign w_unused_parity = frame_i.parity;

    assign w_frame_ok = !parity_err_i && frame_i.start && frame_i.stop &&
                        ((frame_i.cmd == CMD_READ) || (frame_i.cmd == CMD_WRITE));
    assign w_idle     = (r_state == IDLE);
    assign w_accept   = frame_valid_i && w_idle && w_frame_ok;
    assign w_inc_ferr = frame_valid_i && w_idle && !w_frame_ok;
    assign w_inc_ovr  = frame_valid_i && !w_idle;
    assign w_tmr_zero = (r_timer == '0);
    assign w_inc_tmo  = w_tmr_zero &&
                        (((r_state == REQ) && !gnt_i) ||
                         ((r_state == RD_WAIT) && !rvalid_i));

    function automatic serial_frame_t build_rsp(
        input logic [CMD_W-1:0]         cmd,
        input logic [SERIAL_ADDR_W-1:0] addr,
        input logic [SERIAL_DATA_W-1:0] data
    );
        serial_frame_t f;
        f.start  = 1'b1;
        f.cmd    = cmd;
        f.addr   = addr;
        f.data   = data;
        f.parity = calc_parity(cmd, addr, data);
        f.stop   = 1'b1;
        return f;
    endfunction

    // Transaction sequencer: accept, bus request, read wait, response hand-off
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_frame <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_we    <= (frame_i.cmd == CMD_WRITE);
                        r_cmd   <= frame_i.cmd;
                        r_addr  <= frame_i.addr;
                        r_wdata <= frame_i.data;
                        r_timer <= c_TMR_LOAD;
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (r_cmd == CMD_WRITE) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_frame <= build_rsp(r_cmd, r_addr, r_wdata);
                        end else begin
                            r_state <= RD_WAIT;
                            r_timer <= c_TMR_LOAD;
                        end
                    end else if (w_tmr_zero) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                    end else begin
                        r_timer <= r_timer - c_TMR_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (rvalid_i) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_frame <= build_rsp(r_cmd, r_addr, rdata_i);
                    end else if (w_tmr_zero) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer - c_TMR_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_o       = r_req;
    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_frame_o = r_rsp_frame;
    assign busy_o      = !w_idle;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_ferr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_inc_ferr),
        .cnt_o  (frame_err_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_ovr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_inc_ovr),
        .cnt_o  (overrun_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_tmo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_inc_tmo),
        .cnt_o  (timeout_o)
    );

endmodule

`default_nettype wire
